// File: rtl/global_defs_pkg.sv
// ============================================================================
//  Module   : global_defs (package)
//  Brief    : Shared request types and queue constants for the trace front end.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package global_defs;

    localparam int REQ_QUEUE_DEPTH = 16;

    typedef enum logic [1:0] {
        READ   = 2'd0,
        WRITE  = 2'd1,
        IFETCH = 2'd2
    } opcode_e;

    typedef struct packed {
        logic [31:0] CPU_clock_count;
        opcode_e     opcode;
        logic [31:0] address;
        logic        op_ready_s;
    } parser_out_struct;

    // Per-slot age update selection driven by the queue compaction logic
    typedef enum logic [1:0] {
        AGE_HOLD_INC  = 2'd0,
        AGE_SHIFT_IN  = 2'd1,
        AGE_LOAD_ZERO = 2'd2
    } age_mode_e;

endpackage

`default_nettype wire

// File: rtl/age_counter.sv
// ============================================================================
//  Module   : age_counter
//  Brief    : Saturating age counter with load-zero, shift-in and hold-increment.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module age_counter
    import global_defs::*;
#(
    parameter int AGE_WIDTH = 8
) (
    input  logic                 CPU_clock,
    input  logic                 rst,
    input  age_mode_e            mode_i,
    input  logic [AGE_WIDTH-1:0] shift_val_i,
    output logic [AGE_WIDTH-1:0] age_o
);

    logic [AGE_WIDTH-1:0] age_q;
    logic [AGE_WIDTH-1:0] age_d;

    function automatic logic [AGE_WIDTH-1:0] sat_inc(input logic [AGE_WIDTH-1:0] v);
        return (v == {AGE_WIDTH{1'b1}}) ? v : v + AGE_WIDTH'(1);
    endfunction

    always_comb begin
        age_d = age_q;
        case (mode_i)
            AGE_HOLD_INC:  age_d = sat_inc(age_q);
            AGE_SHIFT_IN:  age_d = sat_inc(shift_val_i);
            AGE_LOAD_ZERO: age_d = '0;
            default:       age_d = '0;
        endcase
    end

    always_ff @(posedge CPU_clock or posedge rst) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign age_o = age_q;

endmodule

`default_nettype wire

// File: rtl/mc_request_queue.sv
// ============================================================================
//  Module   : mc_request_queue
//  Brief    : In-order insert, any-index remove request queue with entry ageing.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mc_request_queue
    import global_defs::*;
#(
    parameter int DEPTH        = REQ_QUEUE_DEPTH,
    parameter int AGE_WIDTH    = 8,
    parameter int STARVE_LIMIT = 100,
    parameter int IDX_WIDTH    = $clog2(DEPTH)
) (
    input  logic                 CPU_clock,
    input  logic                 rst,
    input  logic                 in_valid,
    input  parser_out_struct     in_req,
    output logic                 in_ready,
    input  logic                 pop_valid,
    input  logic [IDX_WIDTH-1:0] pop_idx,
    output parser_out_struct     q_entry [DEPTH],
    output logic [DEPTH-1:0]     q_valid,
    output logic [AGE_WIDTH-1:0] q_age   [DEPTH],
    output logic [IDX_WIDTH:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 starve,
    output logic                 err_pop
);

    localparam int                   CNT_W    = IDX_WIDTH + 1;
    localparam logic [CNT_W-1:0]     C_DEPTH  = CNT_W'(DEPTH);
    localparam logic [AGE_WIDTH-1:0] C_STARVE = AGE_WIDTH'(STARVE_LIMIT);

    parser_out_struct     entry_q   [DEPTH];
    parser_out_struct     entry_d   [DEPTH];
    parser_out_struct     entry_ext [DEPTH+1];
    logic [AGE_WIDTH-1:0] age       [DEPTH];
    logic [AGE_WIDTH-1:0] age_ext   [DEPTH+1];
    logic [AGE_WIDTH-1:0] age_shift [DEPTH];
    age_mode_e            age_mode  [DEPTH];

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] post_pop_cnt;
    logic             err_pop_q;
    logic             err_pop_d;
    logic             push_acc;
    logic             pop_ok;

    assign full     = (count_q == C_DEPTH);
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push_acc = in_valid && in_ready;
    assign pop_ok   = pop_valid && ({1'b0, pop_idx} < count_q);

    // Compaction happens first, so a concurrent push lands at the post-pop tail
    assign post_pop_cnt = count_q - CNT_W'(pop_ok);
    assign count_d      = post_pop_cnt + CNT_W'(push_acc);
    assign err_pop_d    = err_pop_q | (pop_valid & ~pop_ok);

    // One extra zero slot above the top lets the shift mux stay uniform
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_ext[i] = entry_q[i];
            age_ext[i]   = age[i];
        end
        entry_ext[DEPTH] = '0;
        age_ext[DEPTH]   = '0;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i]   = entry_q[i];
            age_mode[i]  = AGE_HOLD_INC;
            age_shift[i] = age_ext[i+1];
            if (pop_ok && (CNT_W'(i) >= {1'b0, pop_idx})) begin
                entry_d[i]  = entry_ext[i+1];
                age_mode[i] = AGE_SHIFT_IN;
            end
            if (push_acc && (CNT_W'(i) == post_pop_cnt)) begin
                entry_d[i]  = in_req;
                age_mode[i] = AGE_LOAD_ZERO;
            end
            if (CNT_W'(i) >= count_d) begin
                age_mode[i] = AGE_LOAD_ZERO;
            end
        end
    end

    always_ff @(posedge CPU_clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count_q   <= '0;
            err_pop_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            count_q   <= count_d;
            err_pop_q <= err_pop_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        age_counter #(
            .AGE_WIDTH (AGE_WIDTH)
        ) u_age (
            .CPU_clock   (CPU_clock),
            .rst         (rst),
            .mode_i      (age_mode[i]),
            .shift_val_i (age_shift[i]),
            .age_o       (age[i])
        );

        assign q_valid[i] = (CNT_W'(i) < count_q);
        assign q_entry[i] = entry_q[i];
        assign q_age[i]   = age[i];
    end

    assign count   = count_q;
    assign err_pop = err_pop_q;
    assign starve  = (count_q != '0) && (age[0] >= C_STARVE);

endmodule

`default_nettype wire

// File: tb/tb_mc_request_queue.sv
// ============================================================================
//  Module   : tb_mc_request_queue
//  Brief    : Directed self-checking bench for mc_request_queue.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mc_request_queue;
    import global_defs::*;

    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic             CPU_clock = 1'b0;
    logic             rst;
    logic             in_valid;
    parser_out_struct in_req;
    logic             pop_valid;
    logic [IDX_W-1:0] pop_idx;

    parser_out_struct q_entry [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [7:0]       q_age   [DEPTH];
    logic [IDX_W:0]   count;
    logic             in_ready, full, empty, starve, err_pop;

    parser_out_struct q_entry2 [DEPTH];
    logic [DEPTH-1:0] q_valid2;
    logic [3:0]       q_age2   [DEPTH];
    logic [IDX_W:0]   count2;
    logic             in_ready2, full2, empty2, starve2, err_pop2;

    int vectors     = 0;
    int miscompares = 0;
    parser_out_struct zero_req;

    always #5 CPU_clock = ~CPU_clock;

    mc_request_queue #(
        .DEPTH(DEPTH), .AGE_WIDTH(8), .STARVE_LIMIT(100)
    ) dut (
        .CPU_clock(CPU_clock), .rst(rst), .in_valid(in_valid), .in_req(in_req),
        .in_ready(in_ready), .pop_valid(pop_valid), .pop_idx(pop_idx),
        .q_entry(q_entry), .q_valid(q_valid), .q_age(q_age), .count(count),
        .full(full), .empty(empty), .starve(starve), .err_pop(err_pop)
    );

    // Narrow-age instance sharing the same stimulus, used for saturation checks
    mc_request_queue #(
        .DEPTH(DEPTH), .AGE_WIDTH(4), .STARVE_LIMIT(10)
    ) dut_sat (
        .CPU_clock(CPU_clock), .rst(rst), .in_valid(in_valid), .in_req(in_req),
        .in_ready(in_ready2), .pop_valid(pop_valid), .pop_idx(pop_idx),
        .q_entry(q_entry2), .q_valid(q_valid2), .q_age(q_age2), .count(count2),
        .full(full2), .empty(empty2), .starve(starve2), .err_pop(err_pop2)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic parser_out_struct mk_req(input logic [31:0] addr, input opcode_e op);
        parser_out_struct r;
        r.CPU_clock_count = addr ^ 32'h5A5A_0000;
        r.opcode          = op;
        r.address         = addr;
        r.op_ready_s      = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge CPU_clock);
        #1;
    endtask

    task automatic sync_reset();
        @(negedge CPU_clock);
        rst = 1'b1;
        @(negedge CPU_clock);
        rst = 1'b0;
    endtask

    initial begin
        zero_req  = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_req    = '0;
        pop_valid = 1'b0;
        pop_idx   = '0;

        // Reset state
        #1;
        chk("rst_count",   count,      5'd0);
        chk("rst_empty",   empty,      1'b1);
        chk("rst_full",    full,       1'b0);
        chk("rst_ready",   in_ready,   1'b1);
        chk("rst_valid",   q_valid,    16'h0000);
        chk("rst_starve",  starve,     1'b0);
        chk("rst_errpop",  err_pop,    1'b0);
        chk("rst_entry0",  q_entry[0], zero_req);
        chk("rst_age0",    q_age[0],   8'd0);
        @(negedge CPU_clock);
        rst = 1'b0;

        // Fill with 0x1000..0x100F
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_req   = mk_req(32'h1000 + 32'(k), READ);
            tick();
        end
        chk("fill_full",   full,                1'b1);
        chk("fill_ready",  in_ready,            1'b0);
        chk("fill_count",  count,               5'd16);
        chk("fill_addr0",  q_entry[0].address,  32'h1000);
        chk("fill_addr15", q_entry[15].address, 32'h100F);
        chk("fill_valid",  q_valid,             16'hFFFF);
        chk("fill_age0",   q_age[0],            8'd15);
        chk("fill_age15",  q_age[15],           8'd0);

        // 17th push held three cycles must be refused
        in_req = mk_req(32'hDEAD, WRITE);
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("ovf_count",   count,               5'd16);
        chk("ovf_addr15",  q_entry[15].address, 32'h100F);

        // Pop index 5 from a full queue
        pop_valid = 1'b1;
        pop_idx   = 4'd5;
        tick();
        pop_valid = 1'b0;
        chk("pop5_count",  count,               5'd15);
        chk("pop5_addr5",  q_entry[5].address,  32'h1006);
        chk("pop5_addr14", q_entry[14].address, 32'h100F);
        chk("pop5_valid",  q_valid,             16'h7FFF);
        chk("pop5_top",    q_entry[15],         zero_req);
        chk("pop5_age15",  q_age[15],           8'd0);
        chk("pop5_age5",   q_age[5],            8'd13);
        chk("pop5_age4",   q_age[4],            8'd15);
        chk("pop5_age0",   q_age[0],            8'd19);

        // Drain head until four entries remain
        pop_valid = 1'b1;
        pop_idx   = 4'd0;
        for (int k = 0; k < 11; k++) tick();
        pop_valid = 1'b0;
        chk("drain_count", count,              5'd4);
        chk("drain_head",  q_entry[0].address, 32'h100C);
        chk("drain_valid", q_valid,            16'h000F);

        // Simultaneous push and pop of the head
        in_valid  = 1'b1;
        in_req    = mk_req(32'hBEEF0000, WRITE);
        pop_valid = 1'b1;
        pop_idx   = 4'd0;
        tick();
        in_valid  = 1'b0;
        pop_valid = 1'b0;
        chk("pp_count",  count,              5'd4);
        chk("pp_addr3",  q_entry[3].address, 32'hBEEF0000);
        chk("pp_op3",    q_entry[3].opcode,  WRITE);
        chk("pp_age3",   q_age[3],           8'd0);
        chk("pp_addr0",  q_entry[0].address, 32'h100D);
        chk("pp_addr2",  q_entry[2].address, 32'h100F);
        tick();
        chk("pp_age3_next", q_age[3], 8'd1);

        // Starvation and saturation with a single resident entry
        sync_reset();
        in_valid = 1'b1;
        in_req   = mk_req(32'h2000, IFETCH);
        tick();
        in_valid = 1'b0;
        chk("stv_age_start", q_age[0], 8'd0);
        chk("stv_start",     starve,   1'b0);
        for (int n = 1; n <= 110; n++) begin
            tick();
            if (n == 99) begin
                chk("stv_age99",  q_age[0], 8'd99);
                chk("stv_99",     starve,   1'b0);
            end
            if (n == 100) begin
                chk("stv_age100", q_age[0],  8'd100);
                chk("stv_100",    starve,    1'b1);
                chk("sat_age100", q_age2[0], 4'd15);
            end
            if (n == 9)  chk("sat_starve9",  starve2,   1'b0);
            if (n == 10) chk("sat_starve10", starve2,   1'b1);
            if (n == 15) chk("sat_age15",    q_age2[0], 4'd15);
            if (n == 16) chk("sat_age16",    q_age2[0], 4'd15);
        end

        // Illegal pop with two entries resident
        in_valid = 1'b1;
        in_req   = mk_req(32'h2001, READ);
        tick();
        in_valid = 1'b0;
        chk("ill_pre_err", err_pop, 1'b0);
        pop_valid = 1'b1;
        pop_idx   = 4'd3;
        tick();
        pop_valid = 1'b0;
        chk("ill_err",   err_pop,            1'b1);
        chk("ill_count", count,              5'd2);
        chk("ill_valid", q_valid,            16'h0003);
        chk("ill_addr0", q_entry[0].address, 32'h2000);
        chk("ill_addr1", q_entry[1].address, 32'h2001);
        tick(); tick(); tick();
        chk("ill_sticky", err_pop, 1'b1);

        // Async reset mid-cycle while pushing into seven entries
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_req   = mk_req(32'h3000 + 32'(k), READ);
            tick();
        end
        chk("ar_pre_count", count, 5'd7);
        in_req = mk_req(32'h7777, WRITE);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_count",  count,      5'd0);
        chk("ar_empty",  empty,      1'b1);
        chk("ar_ready",  in_ready,   1'b1);
        chk("ar_valid",  q_valid,    16'h0000);
        chk("ar_err",    err_pop,    1'b0);
        chk("ar_entry0", q_entry[0], zero_req);
        chk("ar_age0",   q_age[0],   8'd0);
        tick();
        chk("ar_held_count", count, 5'd0);
        in_valid = 1'b0;
        @(negedge CPU_clock);
        rst = 1'b0;
        tick();
        chk("ar_post_count", count,      5'd0);
        chk("ar_post_empty", empty,      1'b1);
        chk("ar_post_entry", q_entry[0], zero_req);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mc_request_queue.md
# mc_request_queue

Parametrised in-order-insert, out-of-order-remove request queue between the trace parser and the DRAM command scheduler. It accepts `parser_out_struct` requests through a valid/ready handshake and stores them compacted so that index 0 is always the oldest entry. The scheduler can remove any resident entry by index. Each entry carries a saturating age counter, and the block raises a starvation flag when the oldest request waits too long.

## Interface
- `DEPTH`, 16, number of entries (≥2)
- `AGE_WIDTH`, 8, width of per-entry age counter
- `STARVE_LIMIT`, 100, head age (cycles) at or above which `starve` asserts; must be < 2^AGE_WIDTH
- `IDX_WIDTH`, $clog2(DEPTH), derived; index width
- `CPU_clock`  in  1  single clock, all state updates on posedge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  parser offers a request
- `in_req`  in  parser_out_struct  request (CPU_clock_count, opcode, address, op_ready_s)
- `in_ready`  out  1  queue can accept this cycle
- `pop_valid`  in  1  scheduler removes an entry this cycle
- `pop_idx`  in  IDX_WIDTH  index of entry to remove
- `q_entry`  out  parser_out_struct [DEPTH]  stored entries, index 0 oldest
- `q_valid`  out  DEPTH  bit i set iff entry i occupied (always a thermometer code)
- `q_age`  out  AGE_WIDTH [DEPTH]  age of each entry
- `count`  out  IDX_WIDTH+1  occupancy 0..DEPTH
- `full` / `empty`  out  1  count==DEPTH / count==0
- `starve`  out  1  q_valid[0] && q_age[0] ≥ STARVE_LIMIT
- `err_pop`  out  1  sticky: pop of unoccupied index seen

## Operation
- Push is accepted when `in_valid && in_ready`. `in_ready = !full` (combinational, no same-cycle pop bypass).
- Pop is legal when `pop_valid && pop_idx < count`. The entry is removed, entries above it shift down one, and their ages are preserved and incremented.
- Illegal pop (`pop_idx ≥ count`, including any pop while empty) makes no change and sets `err_pop`. `err_pop` clears only on reset.
- Simultaneous legal push and pop: compaction first, then the new entry lands at index count-1. `count` is unchanged.
- Push only: the new entry is placed at index `count`, and `count` increments. Pop only: `count` decrements.
- Ages: every resident entry increments by 1 each cycle and saturates at 2^AGE_WIDTH-1. A newly inserted entry has age 0 in its first visible cycle.
- Unoccupied slots read entry = all zeros and age = 0.
- Reset (any time, including mid push/pop) clears all entries, ages, `count`, and `err_pop`. Requests in flight are dropped.

## Timing
- Reset values: `q_entry` all 0, `q_valid` 0, `q_age` all 0, `count` 0, `empty` 1, `full` 0, `in_ready` 1, `starve` 0, `err_pop` 0.
- Insert latency 1 cycle: a request accepted at edge N is visible on `q_entry`/`q_valid` after edge N.
- Removal latency 1 cycle: an entry popped at edge N is gone after edge N.
- `full`, `empty`, `in_ready`, and `starve` are combinational from registered state. They do not depend on same-cycle inputs.
- `err_pop` sets at the edge that samples the illegal pop.

## Structure
- `global_defs` package: reuse `parser_out_struct`. Add `REQ_QUEUE_DEPTH` (16) and the opcode enum (READ=0, WRITE=1, IFETCH=2) if not already present.
- One sub-module, `age_counter`: an AGE_WIDTH saturating counter with load-zero, shift-in (load neighbour value +1), and hold-increment modes. Instantiate it DEPTH times.
- The top level holds the entry array, the compaction shift mux, `count`, and the flags.

## Test plan
- Reset, then push 16 requests with addresses 0x1000..0x100F. Required: `full`=1, `in_ready`=0, `q_entry[0].address`=0x1000, `q_entry[15].address`=0x100F. A 17th push held for 3 cycles is not accepted.
- With the queue full, pop idx 5. Required: `count`=15, `q_entry[5].address`=0x1006, `q_entry[14].address`=0x100F, `q_valid`=16'h7FFF.
- With 4 entries resident, do a simultaneous push (0xBEEF0000) and pop idx 0. Required: `count`=4, `q_entry[3].address`=0xBEEF0000, `q_age[3]`=0 on the next cycle.
- Push one entry and hold for STARVE_LIMIT cycles. Required: `starve` rises exactly when `q_age[0]`=100. With AGE_WIDTH=4, the age saturates at 15 and stays there.
- Pop idx 3 with `count`=2. Required: no state change, and `err_pop`=1 stays set until `rst`.
- Assert `rst` asynchronously mid-cycle while pushing into a queue holding 7 entries. Required: outputs return to reset values immediately, before the next clock edge, and the in-flight push is dropped.
